mpi_rx_credit_fifo: RTL and testbench

//   Downstream stage of the credit-based receiver: buffers each 64-bit word the receiver hands over,

---
 rtl/mpi_rx_credit_fifo.sv | 98 +++++++++
 tb/tb_mpi_rx_credit_fifo.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mpi_rx_credit_fifo.sv
// mpi_rx_credit_fifo
//   Receive-side buffer of the credit-based link. Words handed over by the
//   receiver are stored in a small FIFO and presented to the local consumer
//   with first-word fall-through and a valid/yumi handshake. Every consumed
//   word returns one credit to the remote sender as a single-cycle pulse.
//
// Ports
//   clk         in   single clock, all state updates on the rising edge
//   rst         in   asynchronous active-high reset (release synchronous upstream)
//   in_valid    in   receiver presents a word this cycle
//   in_data     in   word from the receiver
//   out_valid   out  head entry is valid
//   out_data    out  head entry (forced to zero while out_valid is low)
//   out_yumi    in   consumer takes the head entry this cycle
//   cred_ret    out  registered one-cycle pulse, one per consumed word
//   cred_count  out  number of free entries
//   overflow    out  sticky: push while full without a same-cycle pop
//   underflow   out  sticky: out_yumi while the FIFO is empty
module mpi_rx_credit_fifo #(
  parameter int DATA_WIDTH   = 64,
  parameter int DEPTH        = 4,
  parameter int CREDIT_WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [DATA_WIDTH-1:0]   in_data,
  output logic                    out_valid,
  output logic [DATA_WIDTH-1:0]   out_data,
  input  logic                    out_yumi,
  output logic                    cred_ret,
  output logic [CREDIT_WIDTH-1:0] cred_count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      occ;

  logic full;
  logic push;
  logic pop;

  assign full      = (occ == DEPTH_C);
  assign out_valid = (occ != '0);
  assign pop       = out_yumi & out_valid;
  // A full FIFO can still accept a word when the head leaves in the same cycle.
  assign push      = in_valid & (~full | pop);

  assign out_data   = out_valid ? mem[rd_ptr] : '0;
  assign cred_count = CREDIT_WIDTH'(DEPTH) - CREDIT_WIDTH'(occ);

  // Storage is data only; it carries no reset because out_data is masked
  // whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      occ       <= '0;
      cred_ret  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   occ <= occ + CNT_W'(1);
        2'b01:   occ <= occ - CNT_W'(1);
        default: occ <= occ;
      endcase
      cred_ret <= pop;
      if (in_valid & full & ~pop) begin
        overflow <= 1'b1;
      end
      if (out_yumi & ~out_valid) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mpi_rx_credit_fifo.sv
module tb_mpi_rx_credit_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [63:0] in_data = '0;
  logic        out_valid;
  logic [63:0] out_data;
  logic        out_yumi = 1'b0;
  logic        cred_ret;
  logic [2:0]  cred_count;
  logic        overflow;
  logic        underflow;

  int checks = 0;
  int errors = 0;

  // sb: words the FIFO should currently hold.
  // exp_q/obs_q: expected and observed words at each pop.
  logic [63:0] sb[$];
  logic [63:0] exp_q[$];
  logic [63:0] obs_q[$];

  always #5 clk = ~clk;

  mpi_rx_credit_fifo #(.DATA_WIDTH(64), .DEPTH(4), .CREDIT_WIDTH(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .out_yumi(out_yumi),
    .cred_ret(cred_ret), .cred_count(cred_count),
    .overflow(overflow), .underflow(underflow)
  );

  // One clock of stimulus; starts and ends 1 time unit after a rising edge.
  task automatic cycle(input logic v, input logic [63:0] d, input logic y);
    bit pop;
    in_valid = v;
    in_data  = d;
    out_yumi = y;
    #1;
    pop = y && (sb.size() > 0);
    if (pop) begin
      exp_q.push_back(sb.pop_front());
      obs_q.push_back(out_data);
    end
    if (v && sb.size() < 4) sb.push_back(d);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_yumi = 1'b0;
  endtask

  task automatic test_reset();
    // 4 pushes then one pop leaves 3 stored words and cred_ret high.
    for (int i = 0; i < 4; i++) cycle(1'b1, 64'h1000 + 64'(i), 1'b0);
    cycle(1'b0, '0, 1'b1);
    #3 rst = 1'b1;
    #1;
    sb.delete();
    exp_q.delete();
    obs_q.delete();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_data !== 64'h0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
    checks++; if (cred_count !== 3'd4) begin errors++; $display("FAIL reset_cred_count got %0d want 4", cred_count); end
    checks++; if (cred_ret !== 1'b0) begin errors++; $display("FAIL reset_cred_ret got %b want 0", cred_ret); end
    checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL reset_flags got ovf=%b unf=%b want 0 0", overflow, underflow); end
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    cycle(1'b1, 64'hdeedabba_cafeface, 1'b0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", out_valid); end
    checks++; if (out_data !== 64'hdeedabba_cafeface) begin errors++; $display("FAIL single_data got %h want deedabbacafeface", out_data); end
    checks++; if (cred_count !== 3'd3) begin errors++; $display("FAIL single_cred_count got %0d want 3", cred_count); end
    cycle(1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b1);
    checks++; if (cred_ret !== 1'b1) begin errors++; $display("FAIL single_cred_ret got %b want 1", cred_ret); end
    checks++; if (cred_count !== 3'd4) begin errors++; $display("FAIL single_cred_back got %0d want 4", cred_count); end
    cycle(1'b0, '0, 1'b0);
    checks++; if (cred_ret !== 1'b0) begin errors++; $display("FAIL single_cred_pulse got %b want 0", cred_ret); end
    while (exp_q.size() > 0) begin
      logic [63:0] e, o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL single_order got %h want %h", o, e); end
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 4; i++) cycle(1'b1, 64'hA0 + 64'(i), 1'b0);
    checks++; if (cred_count !== 3'd0) begin errors++; $display("FAIL fill_cred_count got %0d want 0", cred_count); end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, '0, 1'b1);
      checks++; if (cred_ret !== 1'b1) begin errors++; $display("FAIL drain_cred_ret[%0d] got %b want 1", i, cred_ret); end
    end
    checks++; if (out_valid !== 1'b0 || out_data !== 64'h0) begin errors++; $display("FAIL drain_empty got v=%b d=%h want 0 0", out_valid, out_data); end
    checks++; if (cred_count !== 3'd4) begin errors++; $display("FAIL drain_cred_count got %0d want 4", cred_count); end
    while (exp_q.size() > 0) begin
      logic [63:0] e, o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL fill_order got %h want %h", o, e); end
    end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 4; i++) cycle(1'b1, 64'hB0 + 64'(i), 1'b0);
    cycle(1'b1, 64'hB4, 1'b1);
    checks++; if (cred_count !== 3'd0) begin errors++; $display("FAIL fullpp_cred_count got %0d want 0", cred_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fullpp_overflow got %b want 0", overflow); end
    checks++; if (cred_ret !== 1'b1) begin errors++; $display("FAIL fullpp_cred_ret got %b want 1", cred_ret); end
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1);
    checks++; if (exp_q.size() !== 5) begin errors++; $display("FAIL fullpp_count got %0d want 5", exp_q.size()); end
    while (exp_q.size() > 0) begin
      logic [63:0] e, o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL fullpp_order got %h want %h", o, e); end
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++) cycle(1'b1, 64'hC0 + 64'(i), 1'b0);
    cycle(1'b1, 64'hCF, 1'b0);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", overflow); end
    checks++; if (cred_count !== 3'd0) begin errors++; $display("FAIL ovf_cred_count got %0d want 0", cred_count); end
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow); end
    checks++; if (obs_q.size() !== 4) begin errors++; $display("FAIL ovf_count got %0d want 4", obs_q.size()); end
    while (exp_q.size() > 0) begin
      logic [63:0] e, o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL ovf_order got %h want %h", o, e); end
    end
  endtask

  task automatic test_underflow_wrap();
    cycle(1'b0, '0, 1'b1);
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL unf_set got %b want 1", underflow); end
    checks++; if (cred_ret !== 1'b0) begin errors++; $display("FAIL unf_cred_ret got %b want 0", cred_ret); end
    checks++; if (cred_count !== 3'd4) begin errors++; $display("FAIL unf_cred_count got %0d want 4", cred_count); end
    for (int i = 0; i < 40; i++) begin
      logic v, y;
      v = 1'($urandom_range(0, 1));
      y = (sb.size() > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      cycle(v, {$urandom, $urandom}, y);
      checks++; if (cred_count !== 3'(4 - sb.size())) begin errors++; $display("FAIL rnd_cred_count[%0d] got %0d want %0d", i, cred_count, 4 - sb.size()); end
    end
    while (sb.size() > 0) cycle(1'b0, '0, 1'b1);
    while (exp_q.size() > 0) begin
      logic [63:0] e, o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL rnd_order got %h want %h", o, e); end
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_fill_drain();
    test_full_push_pop();
    test_overflow();
    test_underflow_wrap();
    test_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
